// File: rtl/pc_sequencer_pkg.sv
// Shared opcode header for the 16-bit core: opcode encodings, instruction field
// positions and the redirect kinds used by the fetch PC sequencer.
package pc_sequencer_pkg;

    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int BOFF_W     = 8;
    localparam int CALL_IMM_W = 12;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LDI  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_MOV  = 4'hB,
        OP_CMP  = 4'hC,
        OP_B    = 4'hD,
        OP_CALL = 4'hE,
        OP_RET  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BRANCH,
        RD_CALL,
        RD_RET
    } redirect_e;

    function automatic opcode_e get_opcode(input logic [15:0] instr);
        return opcode_e'(instr[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Hardware return-address stack: circular buffer with saturating occupancy count
// and sticky overflow/underflow flags.
module ras_stack
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ADDR_W-1:0]            push_data_i,
    output logic [ADDR_W-1:0]            top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [PTR_W-1:0]  topIdx;
    logic              isFull;
    logic              isEmpty;

    assign topIdx  = wp_q - PTR_W'(1);
    assign isFull  = (count_q == CNT_W'(RAS_DEPTH));
    assign isEmpty = (count_q == '0);

    // A push onto a full stack still advances wp, so the oldest entry is the one lost.
    always_comb begin
        wp_d        = wp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push_i) begin
            wp_d = wp_q + PTR_W'(1);
            if (isFull) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (isEmpty) begin
                underflow_d = 1'b1;
            end else begin
                wp_d    = topIdx;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wp_q] <= push_data_i;
        end
    end

    assign top_o       = mem_q[topIdx];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered next-PC generator: owns the fetch PC, resolves B/CALL/RET from EX
// and flushes IF/ID for one cycle on every redirect.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         ex_valid,
    input  logic [15:0]                  ex_instr,
    input  logic [ADDR_W-1:0]            ex_pc,
    input  logic                         branch_taken,
    output logic [ADDR_W-1:0]            pc,
    output logic                         flush,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;

    opcode_e           opcode;
    redirect_e         redirectKind;
    logic [ADDR_W-1:0] exPcPlus1;
    logic [ADDR_W-1:0] branchTarget;
    logic [ADDR_W-1:0] callTarget;
    logic [ADDR_W-1:0] retTarget;
    logic [ADDR_W-1:0] target;
    logic              rasPush;
    logic              rasPop;
    logic [ADDR_W-1:0] rasTop;
    logic [CNT_W-1:0]  rasCount;

    assign opcode       = get_opcode(ex_instr);
    assign exPcPlus1    = ex_pc + ADDR_W'(1);
    assign branchTarget = exPcPlus1 + {{(ADDR_W-BOFF_W){ex_instr[BOFF_W-1]}}, ex_instr[BOFF_W-1:0]};
    assign callTarget   = {ex_pc[ADDR_W-1:CALL_IMM_W], ex_instr[CALL_IMM_W-1:0]};
    // An empty-stack RET falls through to the next sequential instruction.
    assign retTarget    = (rasCount == '0) ? exPcPlus1 : rasTop;

    always_comb begin
        redirectKind = RD_NONE;
        rasPush      = 1'b0;
        rasPop       = 1'b0;
        if (ex_valid) begin
            case (opcode)
                OP_B: begin
                    if (branch_taken) begin
                        redirectKind = RD_BRANCH;
                    end
                end
                OP_CALL: begin
                    redirectKind = RD_CALL;
                    rasPush      = 1'b1;
                end
                OP_RET: begin
                    redirectKind = RD_RET;
                    rasPop       = 1'b1;
                end
                default: begin
                    redirectKind = RD_NONE;
                end
            endcase
        end
    end

    always_comb begin
        target = pc_q;
        case (redirectKind)
            RD_BRANCH: target = branchTarget;
            RD_CALL:   target = callTarget;
            RD_RET:    target = retTarget;
            default:   target = pc_q;
        endcase
    end

    // A redirect wins over a stall so a resolved EX instruction is never lost.
    always_comb begin
        pc_d    = pc_q + ADDR_W'(1);
        flush_d = 1'b0;
        if (redirectKind != RD_NONE) begin
            pc_d    = target;
            flush_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rasPush),
        .pop_i      (rasPop),
        .push_data_i(exPcPlus1),
        .top_o      (rasTop),
        .count_o    (rasCount),
        .overflow_o (ras_overflow),
        .underflow_o(ras_underflow)
    );

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign ras_count = rasCount;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written sequences for
// stall/redirect interaction, RAS boundaries, PC wrap and asynchronous reset.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [15:0] ex_pc;
    logic        branch_taken;
    logic [15:0] pc;
    logic        flush;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        exValid;
        logic [15:0] instr;
        logic [15:0] exPc;
        logic        taken;
        logic [15:0] expPc;
        logic        expFlush;
        logic [3:0]  expCount;
    } vec_t;

    vec_t vecs[18];

    pc_sequencer #(
        .ADDR_W   (16),
        .RAS_DEPTH(8),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_pc        (ex_pc),
        .branch_taken (branch_taken),
        .pc           (pc),
        .flush        (flush),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stall        = v.stall;
        ex_valid     = v.exValid;
        ex_instr     = v.instr;
        ex_pc        = v.exPc;
        branch_taken = v.taken;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall        = 1'b0;
        ex_valid     = 1'b0;
        ex_instr     = 16'h0000;
        ex_pc        = 16'h0000;
        branch_taken = 1'b0;
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        step();
        checkOutput({name, ".pc"}, pc, v.expPc);
        checkOutput({name, ".flush"}, 16'(flush), 16'(v.expFlush));
        checkOutput({name, ".count"}, 16'(ras_count), 16'(v.expCount));
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] callPc;
        logic [15:0] tgt;

        rst = 1'b0;
        clearInputs();
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.pc", pc, 16'h0000);
        checkOutput("reset.flush", 16'(flush), 16'h0000);
        checkOutput("reset.count", 16'(ras_count), 16'h0000);
        checkOutput("reset.ovf", 16'(ras_overflow), 16'h0000);
        checkOutput("reset.unf", 16'(ras_underflow), 16'h0000);
        rst = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'h0001, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'h0002, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, {OP_B, 4'h0, 8'hAB},      16'h0055, 1'b1, 16'h0001, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, {OP_B, 4'h0, 8'hAB},      16'h0055, 1'b0, 16'h0002, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, {OP_CALL, 12'h000},       16'hC0DA, 1'b0, 16'hC000, 1'b1, 4'd1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'hC001, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 1'b1, {OP_RET, 12'h000},        16'h1000, 1'b0, 16'hC0DB, 1'b1, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'hC0DB, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b1, {OP_B, 4'h0, 8'h05},      16'h0010, 1'b1, 16'h0016, 1'b1, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'h0016, 1'b0, 4'd0};
        vecs[10] = '{1'b0, 1'b0, {OP_CALL, 12'h123},       16'h2222, 1'b0, 16'h0017, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 1'b1, {OP_ADD, 12'hFFF},        16'h3333, 1'b1, 16'h0018, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 1'b1, {OP_B, 4'h0, 8'h7F},      16'hFFF0, 1'b1, 16'h0070, 1'b1, 4'd0};
        vecs[13] = '{1'b0, 1'b1, {OP_CALL, 12'hABC},       16'h3456, 1'b0, 16'h3ABC, 1'b1, 4'd1};
        vecs[14] = '{1'b0, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'h3ABD, 1'b0, 4'd1};
        vecs[15] = '{1'b0, 1'b1, {OP_RET, 12'h000},        16'h0000, 1'b0, 16'h3457, 1'b1, 4'd0};
        vecs[16] = '{1'b0, 1'b1, {OP_B, 4'h0, 8'h80},      16'h0000, 1'b1, 16'hFF81, 1'b1, 4'd0};
        vecs[17] = '{1'b0, 1'b0, 16'h0000,                 16'h0000, 1'b0, 16'hFF82, 1'b0, 4'd0};

        for (int i = 0; i < 18; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end
        clearInputs();

        // Stall holds the PC; a taken branch still redirects through the stall.
        runVec('{1'b0, 1'b1, {OP_CALL, 12'h234}, 16'h1000, 1'b0, 16'h1234, 1'b1, 4'd1}, "stall.setup");
        for (int i = 0; i < 3; i++) begin
            runVec('{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0, 4'd1}, $sformatf("stall.hold%0d", i));
        end
        runVec('{1'b1, 1'b1, {OP_B, 4'h0, 8'h10}, 16'h1234, 1'b1, 16'h1245, 1'b1, 4'd1}, "stall.redirect");
        runVec('{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1245, 1'b0, 4'd1}, "stall.after");
        clearInputs();

        // RAS boundaries: nine nested calls, eight returns, then one on empty.
        doReset();
        for (int k = 1; k <= 9; k++) begin
            callPc = 16'(k * 16'h1011);
            tgt    = {callPc[15:12], 12'h000};
            runVec('{1'b0, 1'b1, {OP_CALL, 12'h000}, callPc, 1'b0, tgt, 1'b1, 4'((k > 8) ? 8 : k)},
                   $sformatf("ras.call%0d", k));
            if (k == 8) checkOutput("ras.ovf_at8", 16'(ras_overflow), 16'h0000);
        end
        checkOutput("ras.ovf_at9", 16'(ras_overflow), 16'h0001);
        for (int j = 0; j < 8; j++) begin
            tgt = 16'((9 - j) * 16'h1011 + 1);
            runVec('{1'b0, 1'b1, {OP_RET, 12'h000}, 16'h5000, 1'b0, tgt, 1'b1, 4'(7 - j)},
                   $sformatf("ras.ret%0d", j));
        end
        checkOutput("ras.unf_before", 16'(ras_underflow), 16'h0000);
        runVec('{1'b0, 1'b1, {OP_RET, 12'h000}, 16'h7770, 1'b0, 16'h7771, 1'b1, 4'd0}, "ras.ret_empty");
        checkOutput("ras.unf_after", 16'(ras_underflow), 16'h0001);
        runVec('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h7772, 1'b0, 4'd0}, "ras.idle");

        // PC wraps from all-ones to zero.
        runVec('{1'b0, 1'b1, {OP_B, 4'h0, 8'h0E}, 16'hFFF0, 1'b1, 16'hFFFF, 1'b1, 4'd0}, "wrap.setup");
        runVec('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0}, "wrap.zero");

        // Asynchronous reset between edges with a CALL in EX.
        runVec('{1'b0, 1'b1, {OP_CALL, 12'h345}, 16'h2000, 1'b0, 16'h2345, 1'b1, 4'd1}, "arst.setup");
        applyStimulus('{1'b0, 1'b1, {OP_CALL, 12'h111}, 16'h3000, 1'b0, 16'h0000, 1'b0, 4'd0});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.pc", pc, 16'h0000);
        checkOutput("arst.flush", 16'(flush), 16'h0000);
        checkOutput("arst.count", 16'(ras_count), 16'h0000);
        checkOutput("arst.ovf", 16'(ras_overflow), 16'h0000);
        checkOutput("arst.unf", 16'(ras_underflow), 16'h0000);
        step();
        checkOutput("arst.edge_count", 16'(ras_count), 16'h0000);
        checkOutput("arst.edge_pc", pc, 16'h0000);
        rst = 1'b0;
        clearInputs();
        runVec('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 4'd0}, "arst.release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered next-PC generator for the 16-bit pipelined core. It is a parametrised successor of the combinational jump logic.
- Owns the fetch PC register.
- Resolves B, CALL and RET from the EX stage.
- Keeps a hardware return-address stack (RAS) so RET needs no memory access.
- Issues a one-cycle flush to IF/ID on every redirect.

Parameters:
ADDR_W, 16, PC/address width; must be >= 12.
RAS_DEPTH, 8, return-address stack entries; power of two, >= 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous active-high reset.
stall  input  1  hazard stall; holds PC when no redirect is pending.
ex_valid  input  1  EX stage holds a live instruction (not a bubble).
ex_instr  input  16  EX-stage instruction; opcode is [15:12].
ex_pc  input  ADDR_W  address of the EX-stage instruction.
branch_taken  input  1  condition result for a B in EX.
pc  output  ADDR_W  current fetch address (registered).
flush  output  1  registered; kill the IF/ID contents this cycle.
ras_count  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
ras_overflow  output  1  sticky; a CALL was pushed onto a full stack.
ras_underflow  output  1  sticky; a RET executed on an empty stack.

Behaviour:
Reset (asynchronous, rst=1):
- pc=RESET_PC, flush=0, ras_count=0, ras_overflow=0, ras_underflow=0.
- The RAS write pointer is 0. Entry contents are don't-care.
- Reset mid-operation discards any pending redirect and all stack contents.

Redirect decode (combinational; valid only when ex_valid=1):
- B with branch_taken=1: target = ex_pc + 1 + sign-extend(ex_instr[7:0]), modulo 2^ADDR_W.
- B with branch_taken=0: no redirect.
- CALL: target = {ex_pc[ADDR_W-1:12], ex_instr[11:0]}. Also push ex_pc+1.
- RET, stack non-empty: target = top of stack. Also pop.
- RET, stack empty: target = ex_pc+1. Set ras_underflow. ras_count stays 0 and the pointer is unchanged.
- All other opcodes, and ex_valid=0: no redirect, no stack action.

Clocked update, priority redirect > stall > increment:
- Redirect: pc <= target; flush <= 1. A redirect is taken even when stall=1.
- Else if stall: pc holds; flush <= 0.
- Else: pc <= pc+1, wrapping from all-ones to 0; flush <= 0.
- Latency: a redirect is visible on pc exactly one edge after the EX cycle.
- flush is high in the same cycle the new pc appears, and stays high for exactly one cycle per redirect.

RAS (circular buffer, write pointer wp):
- Push: mem[wp] <= ex_pc+1; wp <= wp+1 mod RAS_DEPTH; ras_count <= min(ras_count+1, RAS_DEPTH).
- Push when full: overwrites the oldest entry and sets ras_overflow. ras_count stays at RAS_DEPTH.
- Pop: top = mem[wp-1]; wp <= wp-1; ras_count <= ras_count-1.
- At most one stack action per cycle, since only one EX instruction exists per cycle.
- Sticky flags clear only on reset.

Upstream contract:
- ex_valid must be high for exactly one cycle per EX instruction.
- The flush guarantees that a redirected instruction is not re-presented.
- A duplicate presentation would double-push or double-pop.

Decomposition:
- Opcode constants (ADD..RET, including B, CALL, RET) live in the shared opcode header.
- Add OPC_MSB/OPC_LSB and the B offset field width (8) and CALL immediate width (12) there as constants.
- One natural sub-module: ras_stack. It is parametrised by ADDR_W and RAS_DEPTH, has push/pop/push_data ports, and outputs top/count/overflow/underflow.
- Target muxing and the PC register stay in pc_sequencer.

Test Plan:
1. Reset and increment: assert rst, release with stall=0 and no EX instructions -> pc=0000, then 0001, 0002 on successive edges; flush=0 throughout.
2. Branch: ex_pc=0055, B with offset -8'h55, branch_taken=1 -> next pc=0001, flush=1 for one cycle. Same instruction with branch_taken=0 -> no redirect, pc increments.
3. Call/return: CALL at ex_pc=C0DA, imm=000 -> pc=C000, ras_count=1. Later RET in EX -> pc=C0DB, ras_count=0, flush=1 on each redirect.
4. Stall versus redirect: stall=1 held, pc=1234 holds for 3 cycles. A taken B arriving during the stall -> pc moves to its target on the next edge despite the stall.
5. RAS boundaries (RAS_DEPTH=8): 9 nested CALLs -> ras_count=8, ras_overflow=1. Then 8 RETs return addresses of CALLs 9..2 in order. A 9th RET -> pc=ex_pc+1, ras_underflow=1.
6. Wrap and async reset: pc=FFFF with no stall -> pc=0000. Assert rst between clock edges while a CALL is in EX -> outputs go to reset values immediately and no push occurs.
